load_store_unit: RTL and testbench

- Sits directly upstream of the unified ROM/RAM memory block.
- Accepts one load or store request at a time from the CPU pipeline MEM stage and drives the memory's word-wide address/read/write/data interface.
- Memory supports only 32-bit word writes, so byte and halfword stores use read-modify-write. Loads are extracted and sign- or zero-extended here.
- Region decode: address bit 10 = 0 is ROM (read-only), bit 10 = 1 is RAM.

---
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine in front of the
// unified ROM/RAM word memory. Sub-word stores use read-modify-write; loads
// are lane-extracted and sign/zero-extended here.
// Optional build macro LSU_STATS_EN adds saturating 16-bit completion counters.
//
// state | meaning
// IDLE  | ready for a request, no memory activity
// READ  | memReadEnable held for MEM_READ_LATENCY cycles, word captured on last
// WRITE | single memWriteEnable cycle (word store or merged sub-word store)
// RESP  | one-cycle response pulse with data / error
module load_store_unit #(
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respError,
  output logic [31:0] memAddress,
  output logic        memReadEnable,
  output logic        memWriteEnable,
  output logic [31:0] memDataIn,
  input  logic [31:0] memDataOut
`ifdef LSU_STATS_EN
  ,
  output logic [15:0] statLoads,
  output logic [15:0] statStores,
  output logic [15:0] statErrors
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [2:0] LAT_LAST = 3'(MEM_READ_LATENCY - 1);

  state_t      state, state_next;
  logic [31:0] addr_q, data_q, buf_q;
  logic [1:0]  size_q;
  logic        write_q, unsigned_q, err_q;
  logic [2:0]  cnt_q;
  logic        mem_read_q, mem_write_q;
  logic        req_err;
  logic [31:0] load_val, merged;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Request legality, checked in priority order at the handshake
  always_comb begin
    req_err = 1'b0;
    if (reqSize == 2'b11)                              req_err = 1'b1;
    else if (reqSize == 2'b01 && reqAddress[0])        req_err = 1'b1;
    else if (reqSize == 2'b10 && reqAddress[1:0] != 2'b00) req_err = 1'b1;
    else if (reqWrite && !reqAddress[10])              req_err = 1'b1;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (reqValid) begin
        if (req_err)                             state_next = RESP;
        else if (!reqWrite || reqSize != 2'b10)  state_next = READ;
        else                                     state_next = WRITE;
      end
      READ:    if (cnt_q == 3'd0) state_next = write_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, registered strobes, request latch, read counter and word buffer
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      buf_q       <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      unsigned_q  <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state       <= state_next;
      mem_read_q  <= (state_next == READ);
      mem_write_q <= (state_next == WRITE);
      if (state == IDLE && reqValid) begin
        addr_q     <= reqAddress;
        data_q     <= reqData;
        size_q     <= reqSize;
        write_q    <= reqWrite;
        unsigned_q <= reqUnsigned;
        err_q      <= req_err;
        cnt_q      <= LAT_LAST;
      end else if (state == READ) begin
        if (cnt_q == 3'd0) buf_q <= memDataOut;
        else               cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  // Load lane extraction and store lane merge
  always_comb begin
    byte_sel = buf_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? buf_q[31:16] : buf_q[15:0];
    case (size_q)
      2'b00:   load_val = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~unsigned_q & half_sel[15]}}, half_sel};
      default: load_val = buf_q;
    endcase
    merged = buf_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
      default: merged = data_q;
    endcase
  end

  // Output drive; reqReady held low while reset is asserted
  always_comb begin
    reqReady       = (state == IDLE) && resetN;
    respValid      = (state == RESP);
    respError      = (state == RESP) && err_q;
    respData       = (state == RESP && !err_q && !write_q) ? load_val : 32'h0;
    memAddress     = {addr_q[31:2], 2'b00};
    memReadEnable  = mem_read_q;
    memWriteEnable = mem_write_q;
    memDataIn      = mem_write_q ? merged : 32'h0;
  end

`ifdef LSU_STATS_EN
  // Saturating completion counters, bumped in the response cycle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      statLoads  <= '0;
      statStores <= '0;
      statErrors <= '0;
    end else if (state == RESP) begin
      if (err_q) begin
        if (statErrors != 16'hFFFF) statErrors <= statErrors + 16'd1;
      end else if (write_q) begin
        if (statStores != 16'hFFFF) statStores <= statStores + 16'd1;
      end else begin
        if (statLoads != 16'hFFFF) statLoads <= statLoads + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: instance a uses latency 1, instance b
// latency 3. Each has a small word memory model that only presents valid read
// data on the last cycle of a correctly-timed read burst.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_address, req_data;

  logic        valid_a, ready_a, rv_a, re_a, we_a, err_a;
  logic [31:0] rd_a, maddr_a, din_a, dout_a;
  logic        valid_b, ready_b, rv_b, re_b, we_b, err_b;
  logic [31:0] rd_b, maddr_b, din_b, dout_b;
`ifdef LSU_STATS_EN
  logic [15:0] sl_a, ss_a, se_a, sl_b, ss_b, se_b;
`endif

  load_store_unit #(.MEM_READ_LATENCY(1)) u_a (
    .clk(clk), .resetN(rst_n), .reqValid(valid_a), .reqReady(ready_a),
    .reqWrite(req_write), .reqSize(req_size), .reqUnsigned(req_unsigned),
    .reqAddress(req_address), .reqData(req_data), .respValid(rv_a),
    .respData(rd_a), .respError(err_a), .memAddress(maddr_a),
    .memReadEnable(re_a), .memWriteEnable(we_a), .memDataIn(din_a),
    .memDataOut(dout_a)
`ifdef LSU_STATS_EN
    , .statLoads(sl_a), .statStores(ss_a), .statErrors(se_a)
`endif
  );

  load_store_unit #(.MEM_READ_LATENCY(3)) u_b (
    .clk(clk), .resetN(rst_n), .reqValid(valid_b), .reqReady(ready_b),
    .reqWrite(req_write), .reqSize(req_size), .reqUnsigned(req_unsigned),
    .reqAddress(req_address), .reqData(req_data), .respValid(rv_b),
    .respData(rd_b), .respError(err_b), .memAddress(maddr_b),
    .memReadEnable(re_b), .memWriteEnable(we_b), .memDataIn(din_b),
    .memDataOut(dout_b)
`ifdef LSU_STATS_EN
    , .statLoads(sl_b), .statStores(ss_b), .statErrors(se_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  int rc_a = 0, rc_b = 0, we_cnt_a = 0, we_cnt_b = 0;

  always @(posedge clk) begin
    rc_a <= re_a ? rc_a + 1 : 0;
    rc_b <= re_b ? rc_b + 1 : 0;
    if (we_a) begin mem_a[maddr_a[11:2]] <= din_a; we_cnt_a <= we_cnt_a + 1; end
    if (we_b) begin mem_b[maddr_b[11:2]] <= din_b; we_cnt_b <= we_cnt_b + 1; end
  end

  assign dout_a = (re_a && rc_a == 0) ? mem_a[maddr_a[11:2]] : 32'hBAD0BAD0;
  assign dout_b = (re_b && rc_b == 2) ? mem_b[maddr_b[11:2]] : 32'hBAD0BAD0;

  // Selected-instance view
  logic        sel;
  logic        c_rv, c_re, c_we, c_err, c_ready;
  logic [31:0] c_rd, c_maddr, c_din;
  assign c_rv    = sel ? rv_b    : rv_a;
  assign c_re    = sel ? re_b    : re_a;
  assign c_we    = sel ? we_b    : we_a;
  assign c_err   = sel ? err_b   : err_a;
  assign c_ready = sel ? ready_b : ready_a;
  assign c_rd    = sel ? rd_b    : rd_a;
  assign c_maddr = sel ? maddr_b : maddr_a;
  assign c_din   = sel ? din_b   : din_a;

  int vectors = 0;
  int errors  = 0;

  int          got_cycle, re_n, we_n, both_n, busy_ready;
  logic [31:0] got_data, w_addr, w_data;
  logic        got_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request; records response cycle (relative to the accepting edge),
  // strobe counts and the last write seen.
  task automatic txn(input logic s, input logic w, input logic [1:0] sz,
                     input logic u, input logic [31:0] ad, input logic [31:0] dt);
    sel = s;
    @(negedge clk);
    req_write = w; req_size = sz; req_unsigned = u; req_address = ad; req_data = dt;
    if (s) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0;
    got_cycle = 0; re_n = 0; we_n = 0; both_n = 0; busy_ready = 0;
    got_data = 32'hx; got_err = 1'bx; w_addr = 32'h0; w_data = 32'h0;
    for (int n = 1; n <= 20 && got_cycle == 0; n++) begin
      if (c_ready) busy_ready++;
      if (c_re) re_n++;
      if (c_we) begin we_n++; w_addr = c_maddr; w_data = c_din; end
      if (c_re && c_we) both_n++;
      if (c_rv) begin
        got_cycle = n; got_data = c_rd; got_err = c_err;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic chk_resp(input string tag, input int cyc, input logic [31:0] data,
                          input logic err, input int rn, input int wn);
    chk({tag, " cycle"}, got_cycle, cyc);
    chk({tag, " data"},  got_data, data);
    chk({tag, " err"},   {31'h0, got_err}, {31'h0, err});
    chk({tag, " reads"}, re_n, rn);
    chk({tag, " writes"}, we_n, wn);
    chk({tag, " both"},  both_n, 0);
    chk({tag, " ready_busy"}, busy_ready, 0);
  endtask

  int we_snap;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    sel = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_address = 32'h0; req_data = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst ready",  {31'h0, ready_a}, 32'h0);
    chk("rst rv",     {31'h0, rv_a}, 32'h0);
    chk("rst re",     {31'h0, re_a}, 32'h0);
    chk("rst we",     {31'h0, we_a}, 32'h0);
    chk("rst maddr",  maddr_a, 32'h0);
    chk("rst din",    din_a, 32'h0);
    chk("rst rdata",  rd_a, 32'h0);
    chk("rst err",    {31'h0, err_a}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel ready", {31'h0, ready_a}, 32'h1);

    // ---- latency 1 instance ----
    txn(0, 1, 2'b10, 0, 32'h400, 32'hDEADBEEF);
    chk_resp("st_w", 2, 32'h0, 0, 0, 1);
    chk("st_w addr", w_addr, 32'h400);
    chk("st_w data", w_data, 32'hDEADBEEF);

    txn(0, 0, 2'b10, 0, 32'h400, 32'h0);
    chk_resp("ld_w", 2, 32'hDEADBEEF, 0, 1, 0);

    txn(0, 1, 2'b00, 0, 32'h402, 32'h000000AA);
    chk_resp("st_b", 3, 32'h0, 0, 1, 1);
    chk("st_b addr", w_addr, 32'h400);
    chk("st_b data", w_data, 32'hDEAABEEF);

    txn(0, 0, 2'b00, 0, 32'h403, 32'h0);
    chk_resp("ld_sb", 2, 32'hFFFFFFDE, 0, 1, 0);
    txn(0, 0, 2'b00, 1, 32'h403, 32'h0);
    chk_resp("ld_ub", 2, 32'h000000DE, 0, 1, 0);
    txn(0, 0, 2'b01, 0, 32'h400, 32'h0);
    chk_resp("ld_sh", 2, 32'hFFFFBEEF, 0, 1, 0);
    txn(0, 0, 2'b01, 1, 32'h402, 32'h0);
    chk_resp("ld_uh", 2, 32'h0000DEAA, 0, 1, 0);
    txn(0, 0, 2'b00, 1, 32'h401, 32'h0);
    chk_resp("ld_ub1", 2, 32'h000000BE, 0, 1, 0);

    txn(0, 1, 2'b01, 0, 32'h402, 32'h12345678);
    chk_resp("st_h", 3, 32'h0, 0, 1, 1);
    chk("st_h data", w_data, 32'h5678BEEF);
    txn(0, 1, 2'b00, 0, 32'h401, 32'hFFFFFF11);
    chk_resp("st_b1", 3, 32'h0, 0, 1, 1);
    chk("st_b1 data", w_data, 32'h567811EF);
    txn(0, 0, 2'b01, 0, 32'h402, 32'h0);
    chk_resp("ld_sh2", 2, 32'h00005678, 0, 1, 0);

    // errors
    txn(0, 0, 2'b01, 0, 32'h401, 32'h0);
    chk_resp("e_half", 1, 32'h0, 1, 0, 0);
    txn(0, 1, 2'b10, 0, 32'h010, 32'h11111111);
    chk_resp("e_rom", 1, 32'h0, 1, 0, 0);
    txn(0, 0, 2'b10, 0, 32'h402, 32'h0);
    chk_resp("e_word", 1, 32'h0, 1, 0, 0);
    txn(0, 0, 2'b11, 0, 32'h400, 32'h0);
    chk_resp("e_size", 1, 32'h0, 1, 0, 0);
    txn(0, 1, 2'b00, 0, 32'h005, 32'h0);
    chk_resp("e_romb", 1, 32'h0, 1, 0, 0);
    chk("mem after errs", mem_a[10'h100], 32'h567811EF);

    // ---- latency 3 instance ----
    txn(1, 1, 2'b10, 0, 32'h400, 32'hDEADBEEF);
    chk_resp("b st_w", 2, 32'h0, 0, 0, 1);
    txn(1, 0, 2'b00, 0, 32'h401, 32'h0);
    chk_resp("b ld_sb", 4, 32'hFFFFFFBE, 0, 3, 0);
    txn(1, 1, 2'b00, 0, 32'h400, 32'h00000055);
    chk_resp("b st_b", 5, 32'h0, 0, 3, 1);
    chk("b st_b data", w_data, 32'hDEADBE55);

    // reset during the read phase of a sub-word store
    sel = 1'b1;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_address = 32'h401; req_data = 32'h77;
    valid_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_b = 1'b0;
    chk("b rd phase re", {31'h0, re_b}, 32'h1);
    @(negedge clk);
    we_snap = we_cnt_b;
    rst_n = 1'b0;
    #1;
    chk("b rst re",    {31'h0, re_b}, 32'h0);
    chk("b rst we",    {31'h0, we_b}, 32'h0);
    chk("b rst rv",    {31'h0, rv_b}, 32'h0);
    chk("b rst ready", {31'h0, ready_b}, 32'h0);
    chk("b rst maddr", maddr_b, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("b rel ready", {31'h0, ready_b}, 32'h1);
    repeat (6) @(negedge clk);
    chk("b no write", we_cnt_b, we_snap);
    chk("b mem kept", mem_b[10'h100], 32'hDEADBE55);

    // post-reset mix: 2 loads, 1 store, 1 error
    txn(1, 0, 2'b10, 0, 32'h400, 32'h0);
    chk_resp("b ld_w", 4, 32'hDEADBE55, 0, 3, 0);
    txn(1, 0, 2'b01, 1, 32'h402, 32'h0);
    chk_resp("b ld_uh", 4, 32'h0000DEAD, 0, 3, 0);
    txn(1, 1, 2'b10, 0, 32'h404, 32'h01020304);
    chk_resp("b st_w2", 2, 32'h0, 0, 0, 1);
    chk("b st_w2 addr", w_addr, 32'h404);
    txn(1, 0, 2'b10, 0, 32'h401, 32'h0);
    chk_resp("b e_word", 1, 32'h0, 1, 0, 0);
    @(negedge clk);
`ifdef LSU_STATS_EN
    chk("stat loads",  {16'h0, sl_b}, 32'd2);
    chk("stat stores", {16'h0, ss_b}, 32'd1);
    chk("stat errors", {16'h0, se_b}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
